// File: rtl/class_argmax_decoder_pkg.sv
// Shared definitions for the class argmax decoder.
// Default geometry, FSM encoding and result counter width.
package class_argmax_decoder_pkg;

    localparam int DEF_N_CLASS   = 7;
    localparam int DEF_DATA_BITS = 8;
    localparam int CNT_W         = 16;
    localparam int IDX_W         = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/class_argmax_decoder.sv
// Sequential argmax over N_CLASS signed scores, one compare per cycle.
// Registers winner index, score and an LED one-hot map on completion.
module class_argmax_decoder
    import class_argmax_decoder_pkg::*;
#(
    parameter int N_CLASS   = DEF_N_CLASS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         valid_i,
    input  logic [N_CLASS*DATA_BITS-1:0] data_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic [IDX_W-1:0]             class_o,
    output logic [DATA_BITS-1:0]         max_o,
    output logic [N_CLASS-1:0]           onehot_o,
    output logic                         done_o,
    output logic                         overrun_o,
    output logic [CNT_W-1:0]             result_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    state_t r_state;
    state_t w_next_state;

    logic [N_CLASS*DATA_BITS-1:0] r_data;
    logic signed [DATA_BITS-1:0]  r_best;
    logic [IDX_W-1:0]             r_best_idx;
    logic [IDX_W-1:0]             r_idx;

    logic                         r_valid;
    logic [IDX_W-1:0]             r_class;
    logic [DATA_BITS-1:0]         r_max;
    logic [N_CLASS-1:0]           r_onehot;
    logic                         r_done;
    logic                         r_overrun;
    logic [CNT_W-1:0]             r_cnt;

    logic signed [DATA_BITS-1:0]  w_score;
    logic signed [DATA_BITS-1:0]  w_win_val;
    logic [IDX_W-1:0]             w_win_idx;
    logic                         w_gt;
    logic                         w_last;
    logic                         w_start;
    logic                         w_scan;
    logic [N_CLASS-1:0]           w_onehot;

    assign w_scan  = (r_state == S_SCAN);
    assign w_start = (r_state == S_IDLE) && valid_i;
    assign w_last  = w_scan && (r_idx == LAST_IDX);

    // Single shared comparator; strict > keeps the lowest index on ties.
    assign w_score   = r_data[r_idx*DATA_BITS +: DATA_BITS];
    assign w_gt      = w_score > r_best;
    assign w_win_val = w_gt ? w_score : r_best;
    assign w_win_idx = w_gt ? r_idx : r_best_idx;

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            if (w_win_idx == IDX_W'(k)) begin
                w_onehot[N_CLASS-1-k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (valid_i) w_next_state = S_SCAN;
            S_SCAN: if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (clear_i) w_next_state = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            r_data     <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_class    <= '0;
            r_max      <= '0;
            r_onehot   <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_data     <= data_i;
                r_best     <= data_i[DATA_BITS-1:0];
                r_best_idx <= '0;
                r_idx      <= IDX_W'(1);
            end
            if (w_scan) begin
                if (valid_i) r_overrun <= 1'b1;
                r_best     <= w_win_val;
                r_best_idx <= w_win_idx;
                r_idx      <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_valid  <= 1'b1;
                    r_class  <= w_win_idx;
                    r_max    <= w_win_val;
                    r_onehot <= w_onehot;
                    r_done   <= 1'b1;
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o       = w_scan;
    assign valid_o      = r_valid;
    assign class_o      = r_class;
    assign max_o        = r_max;
    assign onehot_o     = r_onehot;
    assign done_o       = r_done;
    assign overrun_o    = r_overrun;
    assign result_cnt_o = r_cnt;

endmodule
